mpsoc_wb_uart_transmitter: RTL
==============================

# mpsoc_wb_uart_transmitter

UART transmit path of the Wishbone UART: a 16-entry TX FIFO written by the register file (THR writes), and a serializer that emits start, 5–8 data bits LSB-first, optional parity and 1/1.5/2 stop bits on `stx_pad_o`. Timing is driven by the shared 16x baud `enable` strobe. It is the counterpart of the receive path and uses the same line-control register encoding.

## Interface
Parameters:
- `FIFO_DEPTH`, 16, TX FIFO entries
- `FIFO_POINTER_W`, 4, log2(FIFO_DEPTH)
- `FIFO_COUNTER_W`, 5, occupancy counter width

Ports:
- `clk` in 1, single clock
- `wb_rst_i` in 1, reset; synchronous, active-high
- `lcr` in 8, line control: [1:0] word length 5/6/7/8, [2] stop bits, [3] PE, [4] EP, [5] SP, [6] break control
- `tf_push` in 1, write `tf_data_in` into FIFO (one entry per cycle high)
- `tf_data_in` in 8, character to send
- `enable` in 1, 16x baud tick (one-cycle strobe)
- `tx_reset` in 1, clear TX FIFO (FCR[2])
- `stx_pad_o` out 1, serial output, idle high
- `tf_count` out FIFO_COUNTER_W, FIFO occupancy 0..16
- `tstate` out 3, serializer state, for LSR THRE/TEMT derivation

## Operation
- Reset: `stx_pad_o`=1, `tstate`=s_idle (0), `tf_count`=0, bit counters 0, FIFO pointers 0.
- FIFO: operates every `clk` (not gated by `enable`). Push when full: data dropped, count stays 16. Pop when empty: ignored. Simultaneous push+pop when empty: push only. Push+pop otherwise: count unchanged. `tx_reset` clears pointers/count next cycle; has priority over a same-cycle push; character already in shift register still completes.
- Serializer advances only on cycles with `enable`=1; 5-bit `counter16` counts ticks per bit.
- States (encoding): s_idle 0, s_pop_byte 1, s_send_start 2, s_send_byte 3, s_send_parity 4, s_send_stop 5.
- s_idle: line high; if `tf_count`!=0 -> s_pop_byte.
- s_pop_byte: one-cycle internal pop; shift register <= FIFO head; `bit_counter` <= word length − 1 (4..7); parity bit computed; line driven low; `counter16`<=15 -> s_send_start.
- s_send_start: when `counter16`==0 drive bit0, `counter16`<=15 -> s_send_byte; else decrement.
- s_send_byte: at `counter16`==0: if `bit_counter`!=0 shift, drive next bit, decrement; else if PE -> drive parity, s_send_parity; else drive 1, s_send_stop with stop ticks loaded.
- Parity ({EP,SP}): 00 odd = ~^data; 10 even = ^data; 01 stick 1; 11 stick 0. Computed over active word bits only.
- Stop length: `lcr[2]`=0 -> 16 ticks; =1 and 5-bit word -> 24; =1 otherwise -> 32.
- s_send_parity: 16 ticks, then drive 1 -> s_send_stop.
- s_send_stop: count down loaded ticks, then -> s_idle.
- Break: `stx_pad_o` = `lcr[6]` ? 0 : serializer line; serializer keeps running underneath.
- `lcr` changes mid-frame take effect at the next bit boundary decision; not protected.

## Timing
- `tf_push` at cycle N -> `tf_count` increments at N+1.
- Each bit = exactly 16 `enable` ticks; 8N1 frame = 160 ticks; 8E2 = 192 ticks.
- Idle with data: start bit begins on the 2nd `enable` after `tf_count` becomes nonzero (idle tick + pop tick).
- Back-to-back characters: 2 extra high ticks between stop end and next start bit (s_idle, s_pop_byte).
- `tf_count` decrements the cycle after the s_pop_byte cycle.
- `stx_pad_o` registered from serializer; break gating is combinational from `lcr[6]`.
- Reset mid-frame: line high and s_idle on next cycle, FIFO emptied.

## Structure
- `mpsoc_uart_wb_pkg`: FIFO width/depth/counter constants, LCR bit indices (`UART_LC_BITS`, `UART_LC_SB`, `UART_LC_PE`, `UART_LC_EP`, `UART_LC_SP`, `UART_LC_BC`), tstate encodings.
- Sub-module `mpsoc_wb_uart_tfifo`: 8-bit synchronous FIFO (push, pop, data_out head, count, fifo_reset); no error bits.
- Top: serializer FSM, counters, parity, break gating.

## Test plan
- 8N1, `enable` every cycle, push 0xA5 -> `stx_pad_o` low 16 cycles, then 1,0,1,0,0,1,0,1 (16 each), high 16, `tstate` back to 0, `tf_count` 1->0.
- 7E1 push 0x35 -> 7 data bits, parity bit 0 (four ones, even), 1 stop; 7O2 -> parity 1, stop 32 ticks; 5-bit, `lcr[2]`=1 -> stop 24 ticks.
- Stick parity {EP,SP}=01 and 11 with 0xFF -> parity bit 1 and 0 respectively.
- Push 17 characters back-to-back -> `tf_count` saturates 16, 17th dropped; 16 frames emitted, each separated by 2 high ticks.
- Set `lcr[6]` mid-frame -> line 0 immediately; clear -> line resumes serializer value; `tx_reset` mid-frame -> current char completes, `tf_count`=0, no further frames.
- `enable` every 4th cycle with 8N1 -> frame spans 640 cycles; `wb_rst_i` mid-frame -> `stx_pad_o`=1, `tstate`=0, `tf_count`=0 next cycle.

Source files
------------

// File: rtl/mpsoc_uart_wb_pkg.sv
// Shared constants and encodings for the Wishbone UART.
// Covers the FIFO sizes, the LCR bit positions and the TX state codes.
package mpsoc_uart_wb_pkg;

  localparam int UART_FIFO_WIDTH     = 8;
  localparam int UART_FIFO_DEPTH     = 16;
  localparam int UART_FIFO_POINTER_W = 4;
  localparam int UART_FIFO_COUNTER_W = 5;

  localparam int UART_LC_BITS = 0;
  localparam int UART_LC_SB   = 2;
  localparam int UART_LC_PE   = 3;
  localparam int UART_LC_EP   = 4;
  localparam int UART_LC_SP   = 5;
  localparam int UART_LC_BC   = 6;

  typedef enum logic [2:0] {
    s_idle        = 3'd0,
    s_pop_byte    = 3'd1,
    s_send_start  = 3'd2,
    s_send_byte   = 3'd3,
    s_send_parity = 3'd4,
    s_send_stop   = 3'd5
  } tstate_t;

  // Stop length in ticks minus one: 16, 24 (5-bit word) or 32.
  function automatic logic [4:0] stop_load(
    input logic       sb,
    input logic [1:0] wl
  );
    if (!sb)
      return 5'd15;
    return (wl == 2'd0) ? 5'd23 : 5'd31;
  endfunction

endpackage

// File: rtl/mpsoc_wb_uart_tfifo.sv
// 8-bit synchronous TX FIFO.
// Drops pushes when full, ignores pops when empty.
module mpsoc_wb_uart_tfifo
  import mpsoc_uart_wb_pkg::*;
#(
  parameter int FIFO_DEPTH     = UART_FIFO_DEPTH,
  parameter int FIFO_POINTER_W = UART_FIFO_POINTER_W,
  parameter int FIFO_COUNTER_W = UART_FIFO_COUNTER_W
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic                      push,
  input  logic                      pop,
  input  logic [7:0]                data_in,
  input  logic                      fifo_reset,
  output logic [7:0]                data_out,
  output logic [FIFO_COUNTER_W-1:0] count
);

  logic [7:0]                mem [FIFO_DEPTH];
  logic [FIFO_POINTER_W-1:0] top;
  logic [FIFO_POINTER_W-1:0] bottom;
  logic                      do_push;
  logic                      do_pop;
  logic                      clr;

  assign clr      = wb_rst_i || fifo_reset;
  assign do_pop   = pop && (count != '0);
  // A pop frees the slot a same-cycle push lands in, even when full.
  assign do_push  = push &&
    ((count != FIFO_COUNTER_W'(FIFO_DEPTH)) || do_pop);
  assign data_out = mem[bottom];

  always_ff @(posedge clk) begin
    if (clr) begin
      top    <= '0;
      bottom <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        top <= top + 1'b1;
      if (do_pop)
        bottom <= bottom + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr)
      mem[top] <= data_in;
  end

endmodule

// File: rtl/mpsoc_wb_uart_transmitter.sv
// UART transmit path: TX FIFO plus a 16x-oversampled serializer.
// Emits start, 5-8 data bits, optional parity and 1/1.5/2 stop bits.
module mpsoc_wb_uart_transmitter
  import mpsoc_uart_wb_pkg::*;
#(
  parameter int FIFO_DEPTH     = UART_FIFO_DEPTH,
  parameter int FIFO_POINTER_W = UART_FIFO_POINTER_W,
  parameter int FIFO_COUNTER_W = UART_FIFO_COUNTER_W
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic [7:0]                lcr,
  input  logic                      tf_push,
  input  logic [7:0]                tf_data_in,
  input  logic                      enable,
  input  logic                      tx_reset,
  output logic                      stx_pad_o,
  output logic [FIFO_COUNTER_W-1:0] tf_count,
  output logic [2:0]                tstate
);

  tstate_t    state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] bc_q, bc_d;
  logic [7:0] sh_q, sh_d;
  logic       par_q, par_d;
  logic       line_q, line_d;
  logic       pop;
  logic [7:0] tf_head;
  logic [7:0] word;
  logic       par_calc;
  logic [1:0] wl;
  logic       unused_lcr;

  assign unused_lcr = lcr[7];
  assign wl         = lcr[UART_LC_BITS +: 2];

  mpsoc_wb_uart_tfifo #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .FIFO_POINTER_W (FIFO_POINTER_W),
    .FIFO_COUNTER_W (FIFO_COUNTER_W)
  ) u_tfifo (
    .clk        (clk),
    .wb_rst_i   (wb_rst_i),
    .push       (tf_push),
    .pop        (pop),
    .data_in    (tf_data_in),
    .fifo_reset (tx_reset),
    .data_out   (tf_head),
    .count      (tf_count)
  );

  assign word = tf_head & (8'hff >> (2'd3 - wl));

  always_comb begin
    par_calc = 1'b0;
    unique case ({lcr[UART_LC_EP], lcr[UART_LC_SP]})
      2'b00: par_calc = ~^word;
      2'b10: par_calc = ^word;
      2'b01: par_calc = 1'b1;
      2'b11: par_calc = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bc_d    = bc_q;
    sh_d    = sh_q;
    par_d   = par_q;
    line_d  = line_q;
    pop     = 1'b0;
    if (enable) begin
      unique case (state_q)
        s_idle: begin
          line_d = 1'b1;
          if (tf_count != '0)
            state_d = s_pop_byte;
        end
        s_pop_byte: begin
          if (tf_count == '0) begin
            state_d = s_idle;
          end else begin
            pop     = 1'b1;
            sh_d    = tf_head;
            bc_d    = {1'b1, wl};
            par_d   = par_calc;
            line_d  = 1'b0;
            cnt_d   = 5'd15;
            state_d = s_send_start;
          end
        end
        s_send_start: begin
          if (cnt_q == '0) begin
            line_d  = sh_q[0];
            cnt_d   = 5'd15;
            state_d = s_send_byte;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        s_send_byte: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 5'd1;
          end else if (bc_q != '0) begin
            sh_d   = sh_q >> 1;
            line_d = sh_q[1];
            bc_d   = bc_q - 3'd1;
            cnt_d  = 5'd15;
          end else if (lcr[UART_LC_PE]) begin
            line_d  = par_q;
            cnt_d   = 5'd15;
            state_d = s_send_parity;
          end else begin
            line_d  = 1'b1;
            cnt_d   = stop_load(lcr[UART_LC_SB], wl);
            state_d = s_send_stop;
          end
        end
        s_send_parity: begin
          if (cnt_q == '0) begin
            line_d  = 1'b1;
            cnt_d   = stop_load(lcr[UART_LC_SB], wl);
            state_d = s_send_stop;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        s_send_stop: begin
          if (cnt_q == '0)
            state_d = s_idle;
          else
            cnt_d = cnt_q - 5'd1;
        end
        default: state_d = s_idle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q <= s_idle;
      cnt_q   <= '0;
      bc_q    <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bc_q    <= bc_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      line_q  <= line_d;
    end
  end

  // Break forces the line low without stopping the serializer.
  assign stx_pad_o = lcr[UART_LC_BC] ? 1'b0 : line_q;
  assign tstate    = state_q;

endmodule
